// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the parameterised UART receiver.
// Contents: FSM state enum, parity-mode enum, per-word error-flag payload,
// minimum data length and counter/index width helpers.
package uart_rx_pkg;

  // Shortest legal data length; shorter requests are promoted to this.
  localparam int unsigned DATA_MIN = 5;

  // Default configuration and the widths it implies.
  localparam int unsigned DATA_MAX_DEF    = 16;
  localparam int unsigned OVER_SAMPLE_DEF = 16;
  localparam int unsigned MID_SAMPLE_DEF  = 8;

  // Width needed to index n items (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CNT_W_DEF = idx_width(OVER_SAMPLE_DEF);
  localparam int unsigned IDX_W_DEF = idx_width(DATA_MAX_DEF);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_mode_t;

  // Error flags travelling with each received word.
  typedef struct packed {
    logic parity_err;
    logic frame_err;
  } rx_flags_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: conditions the raw serial line for the receiver FSM.
// A 2-flop synchroniser (reset to idle-high) feeds the decision logic.
// With UART_RX_MAJORITY_EN defined, the output is the majority of the current
// synchronised value and the values captured on the two preceding i_stick
// ticks; otherwise it is the synchronised value alone.
// Ports:
//   i_clk, i_rst  clock, async active-high reset
//   i_stick       oversample tick (history capture strobe)
//   i_serial      raw serial input
//   o_line_c      conditioned line value (combinational from flops)
module uart_rx_sampler (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stick,
  input  logic i_serial,
  output logic o_line_c
);

  logic [1:0] sync_q;

  // Metastability guard; idles high like the line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], i_serial};
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Line values seen on the two most recent ticks.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        hist_q <= 2'b11;
    else if (i_stick) hist_q <= {hist_q[0], sync_q[1]};
  end

  assign o_line_c = (sync_q[1] & hist_q[0]) |
                    (sync_q[1] & hist_q[1]) |
                    (hist_q[0] & hist_q[1]);
`else
  logic stick_unused;
  assign stick_unused = i_stick;
  assign o_line_c     = sync_q[1];
`endif

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: run-time configurable UART receiver with valid/ready output.
// Optional build macro: UART_RX_MAJORITY_EN (3-tick majority bit decisions).
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_stick             oversample tick, OVER_SAMPLE per bit
//   i_rx_en             enables detection of new frames
//   i_rx_serial         raw serial line (idle high)
//   i_data_bits         data bits per frame (clamped to DATA_MIN..DATA_MAX)
//   i_parity_mode       00 none, 01 even, 10 odd, 11 none
//   i_stop_bits         0 one stop bit, 1 two stop bits
//   i_ready             downstream accept
//   o_rx_data           received word, zero-extended
//   o_rx_valid          word and flags valid
//   o_parity_err        parity mismatch on the presented word
//   o_frame_err         a stop bit was low on the presented word
//   o_overrun           one-cycle pulse when a finished word is dropped
//   o_busy              FSM outside IDLE
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_MAX    = DATA_MAX_DEF,
  parameter int unsigned OVER_SAMPLE = OVER_SAMPLE_DEF,
  parameter int unsigned MID_SAMPLE  = MID_SAMPLE_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_stick,
  input  logic                        i_rx_en,
  input  logic                        i_rx_serial,
  input  logic [$clog2(DATA_MAX):0]   i_data_bits,
  input  logic [1:0]                  i_parity_mode,
  input  logic                        i_stop_bits,
  input  logic                        i_ready,
  output logic [DATA_MAX-1:0]         o_rx_data,
  output logic                        o_rx_valid,
  output logic                        o_parity_err,
  output logic                        o_frame_err,
  output logic                        o_overrun,
  output logic                        o_busy
);

  localparam int unsigned NB_W  = $clog2(DATA_MAX) + 1;
  localparam int unsigned IDX_W = idx_width(DATA_MAX);
  localparam int unsigned CNT_W = idx_width(OVER_SAMPLE);

  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(MID_SAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(OVER_SAMPLE - 1);

  // Map any requested length into the supported range.
  function automatic logic [NB_W-1:0] clamp_bits(input logic [NB_W-1:0] b);
    if (b < NB_W'(DATA_MIN)) return NB_W'(DATA_MIN);
    if (b > NB_W'(DATA_MAX)) return NB_W'(DATA_MAX);
    return b;
  endfunction

  logic                line_c;
  rx_state_t           state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NB_W-1:0]     bit_q;
  logic [NB_W-1:0]     nbits_q;
  parity_mode_t        pmode_q;
  logic                stop2_q;
  logic                stop_idx_q;
  logic [DATA_MAX-1:0] shift_q;
  logic                par_acc_q;
  rx_flags_t           pend_q;
  rx_flags_t           flags_q;
  logic                done_q;
  logic                par_en_c;
  logic                centre_c;

  uart_rx_sampler u_sampler (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_stick  (i_stick),
    .i_serial (i_rx_serial),
    .o_line_c (line_c)
  );

  assign par_en_c = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
  assign centre_c = (cnt_q == CNT_END);

  // Frame FSM; everything advances only on oversample ticks.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      nbits_q    <= NB_W'(DATA_MIN);
      pmode_q    <= PAR_NONE;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      pend_q     <= '0;
      done_q     <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_stick) begin
        unique case (state_q)
          ST_IDLE: begin
            if (i_rx_en && !line_c) begin
              state_q    <= ST_START;
              o_busy     <= 1'b1;
              cnt_q      <= '0;
              bit_q      <= '0;
              stop_idx_q <= 1'b0;
              shift_q    <= '0;
              par_acc_q  <= 1'b0;
              pend_q     <= '0;
              nbits_q    <= clamp_bits(i_data_bits);
              pmode_q    <= parity_mode_t'(i_parity_mode);
              stop2_q    <= i_stop_bits;
            end
          end
          ST_START: begin
            if (cnt_q == CNT_MID) begin
              cnt_q <= '0;
              if (line_c) begin
                state_q <= ST_IDLE;
                o_busy  <= 1'b0;
              end else begin
                state_q <= ST_DATA;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_DATA: begin
            if (centre_c) begin
              cnt_q                      <= '0;
              shift_q[bit_q[IDX_W-1:0]]  <= line_c;
              par_acc_q                  <= par_acc_q ^ line_c;
              if (bit_q == nbits_q - NB_W'(1)) begin
                bit_q   <= '0;
                state_q <= par_en_c ? ST_PARITY : ST_STOP;
              end else begin
                bit_q <= bit_q + NB_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_PARITY: begin
            if (centre_c) begin
              cnt_q   <= '0;
              state_q <= ST_STOP;
              // Even: parity bit equals XOR of data; odd: its inverse.
              if (line_c != (par_acc_q ^ (pmode_q == PAR_ODD)))
                pend_q.parity_err <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_STOP: begin
            if (centre_c) begin
              cnt_q <= '0;
              if (!line_c) pend_q.frame_err <= 1'b1;
              if (stop2_q && !stop_idx_q) begin
                stop_idx_q <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
                o_busy  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            o_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output holding register with valid/ready and overrun detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      flags_q    <= '0;
      o_overrun  <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (done_q) begin
        if (!o_rx_valid || i_ready) begin
          o_rx_data  <= shift_q;
          flags_q    <= pend_q;
          o_rx_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (i_ready) begin
        o_rx_valid <= 1'b0;
      end
    end
  end

  assign o_parity_err = flags_q.parity_err;
  assign o_frame_err  = flags_q.frame_err;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: self-checking bench for uart_rx_param.
// Frame table plus hand sequences (glitch, overrun, mid-frame reset); expected
// words are queued when a frame is driven and compared on each handshake.
module tb_uart_rx_param;

  localparam int unsigned DATA_MAX = 16;
  localparam int unsigned NB_W     = $clog2(DATA_MAX) + 1;
  localparam int          BIT_CYC  = 64;  // 16 ticks x 4 cycles

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic                i_stick;
  logic                i_rx_en;
  logic                i_rx_serial;
  logic [NB_W-1:0]     i_data_bits;
  logic [1:0]          i_parity_mode;
  logic                i_stop_bits;
  logic                i_ready;
  logic [DATA_MAX-1:0] o_rx_data;
  logic                o_rx_valid;
  logic                o_parity_err;
  logic                o_frame_err;
  logic                o_overrun;
  logic                o_busy;

  uart_rx_param #(.DATA_MAX(16), .OVER_SAMPLE(16), .MID_SAMPLE(8)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_stick       (i_stick),
    .i_rx_en       (i_rx_en),
    .i_rx_serial   (i_rx_serial),
    .i_data_bits   (i_data_bits),
    .i_parity_mode (i_parity_mode),
    .i_stop_bits   (i_stop_bits),
    .i_ready       (i_ready),
    .o_rx_data     (o_rx_data),
    .o_rx_valid    (o_rx_valid),
    .o_parity_err  (o_parity_err),
    .o_frame_err   (o_frame_err),
    .o_overrun     (o_overrun),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] data;
    logic        perr;
    logic        ferr;
  } exp_t;

  typedef struct {
    int          cfg;
    int          nb;
    logic [15:0] data;
    logic [1:0]  pm;
    logic        s2;
    logic        badp;
    int          slow;
  } vec_t;

  exp_t sb_q[$];
  exp_t cur;
  vec_t vecs[9];
  int   tests = 0;
  int   fails = 0;
  int   ovr_pulses = 0;
  int   valid_cycles = 0;
  int   div = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Oversample tick every 4 clocks.
  initial begin
    i_stick = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      i_stick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  // Handshake monitor / scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_overrun) ovr_pulses++;
      if (o_rx_valid) valid_cycles++;
      if (o_rx_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got data=%h perr=%b ferr=%b", o_rx_data, o_parity_err, o_frame_err);
        end else begin
          cur = sb_q.pop_front();
          check("rx_data", 32'(o_rx_data), 32'(cur.data));
          check("parity_err", 32'(o_parity_err), 32'(cur.perr));
          check("frame_err", 32'(o_frame_err), 32'(cur.ferr));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(o_rx_data), 32'h0);
    check({tag, "_valid"}, 32'(o_rx_valid), 32'h0);
    check({tag, "_perr"}, 32'(o_parity_err), 32'h0);
    check({tag, "_ferr"}, 32'(o_frame_err), 32'h0);
    check({tag, "_overrun"}, 32'(o_overrun), 32'h0);
    check({tag, "_busy"}, 32'(o_busy), 32'h0);
  endtask

  // Low stop bits are released early so the tail cannot look like a new start.
  task automatic drive_bit(input logic v, input logic partial);
    i_rx_serial = v;
    if (partial) begin
      cyc(48);
      i_rx_serial = 1'b1;
      cyc(BIT_CYC - 48);
    end else begin
      cyc(BIT_CYC);
    end
  endtask

  // Drives one frame; optionally queues its expected word, optionally resets at data bit rst_bit.
  task automatic send_frame(input int cfg, input int nb, input logic [15:0] data,
                            input logic [1:0] pm, input logic s2, input logic badp,
                            input int slow, input logic push, input int rst_bit);
    logic        par;
    logic [16:0] mask;
    exp_t        e;
    par = 1'b0;
    for (int k = 0; k < nb; k++) par ^= data[k];
    if (pm == 2'b10) par = ~par;
    if (badp) par = ~par;
    mask = (17'(1) << nb) - 17'(1);
    if (push) begin
      e.data = data & mask[15:0];
      e.perr = badp && (pm == 2'b01 || pm == 2'b10);
      e.ferr = (slow != 0);
      sb_q.push_back(e);
    end
    i_data_bits   = NB_W'(cfg);
    i_parity_mode = pm;
    i_stop_bits   = s2;
    i_rx_en       = 1'b1;
    drive_bit(1'b0, 1'b0);
    // Config churn and enable drop mid-frame must not disturb this frame.
    i_data_bits   = NB_W'($urandom);
    i_parity_mode = 2'($urandom);
    i_stop_bits   = 1'($urandom);
    i_rx_en       = 1'b0;
    for (int k = 0; k < nb; k++) begin
      if (k == rst_bit) begin
        i_rx_serial = data[k];
        cyc(BIT_CYC / 2);
        i_rst = 1'b1;
        #1;
        check_all_zero("midrst");
        cyc(4);
        i_rst       = 1'b0;
        i_rx_serial = 1'b1;
        i_rx_en     = 1'b1;
        cyc(2 * BIT_CYC);
        return;
      end
      drive_bit(data[k], 1'b0);
    end
    if (pm == 2'b01 || pm == 2'b10) drive_bit(par, 1'b0);
    i_rx_en = 1'b1;
    drive_bit(slow != 1, slow == 1);
    if (s2) drive_bit(slow != 2, slow == 2);
    i_rx_serial = 1'b1;
    cyc(BIT_CYC);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) cyc(1);
    check({tag, "_pending"}, 32'(sb_q.size()), 32'h0);
    sb_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    int v0;
    int o0;
    vecs[0] = '{cfg: 8,  nb: 8,  data: 16'h00A5, pm: 2'b00, s2: 1'b0, badp: 1'b0, slow: 0};
    vecs[1] = '{cfg: 7,  nb: 7,  data: 16'h005A, pm: 2'b01, s2: 1'b0, badp: 1'b1, slow: 0};
    vecs[2] = '{cfg: 16, nb: 16, data: 16'hBEEF, pm: 2'b10, s2: 1'b1, badp: 1'b0, slow: 0};
    vecs[3] = '{cfg: 16, nb: 16, data: 16'hBEEF, pm: 2'b10, s2: 1'b1, badp: 1'b0, slow: 2};
    vecs[4] = '{cfg: 3,  nb: 5,  data: 16'h0015, pm: 2'b00, s2: 1'b0, badp: 1'b0, slow: 0};
    vecs[5] = '{cfg: 31, nb: 16, data: 16'h1234, pm: 2'b00, s2: 1'b0, badp: 1'b0, slow: 0};
    vecs[6] = '{cfg: 8,  nb: 8,  data: 16'h00C3, pm: 2'b11, s2: 1'b0, badp: 1'b0, slow: 0};
    vecs[7] = '{cfg: 5,  nb: 5,  data: 16'h001F, pm: 2'b10, s2: 1'b0, badp: 1'b1, slow: 1};
    vecs[8] = '{cfg: 12, nb: 12, data: 16'h0ABC, pm: 2'b01, s2: 1'b1, badp: 1'b0, slow: 0};

    i_rst         = 1'b1;
    i_rx_en       = 1'b1;
    i_rx_serial   = 1'b1;
    i_data_bits   = NB_W'(8);
    i_parity_mode = 2'b00;
    i_stop_bits   = 1'b0;
    i_ready       = 1'b1;
    cyc(5);
    check_all_zero("reset");
    i_rst = 1'b0;
    cyc(20);

    // Table of frames, always-ready sink: each word valid for exactly one cycle.
    foreach (vecs[i]) begin
      v0 = valid_cycles;
      send_frame(vecs[i].cfg, vecs[i].nb, vecs[i].data, vecs[i].pm, vecs[i].s2,
                 vecs[i].badp, vecs[i].slow, 1'b1, -1);
      drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d_valid_cycles", i), 32'(valid_cycles - v0), 32'd1);
      check($sformatf("vec%0d_busy_after", i), 32'(o_busy), 32'h0);
    end

    // Short low pulse on the line: start rejected, no word.
    v0 = valid_cycles;
    i_rx_serial = 1'b0;
    cyc(12);
    check("glitch_busy_rise", 32'(o_busy), 32'h1);
    cyc(4);
    i_rx_serial = 1'b1;
    cyc(60);
    check("glitch_busy_fall", 32'(o_busy), 32'h0);
    check("glitch_no_valid", 32'(valid_cycles - v0), 32'h0);

    // Stalled sink: second word dropped with a single overrun pulse.
    i_ready = 1'b0;
    o0 = ovr_pulses;
    send_frame(8, 8, 16'h0011, 2'b00, 1'b0, 1'b0, 0, 1'b1, -1);
    check("stall_valid", 32'(o_rx_valid), 32'h1);
    send_frame(8, 8, 16'h0022, 2'b00, 1'b0, 1'b0, 0, 1'b0, -1);
    check("overrun_pulses", 32'(ovr_pulses - o0), 32'h1);
    check("stall_keep_data", 32'(o_rx_data), 32'h0011);
    check("stall_keep_valid", 32'(o_rx_valid), 32'h1);
    i_ready = 1'b1;
    cyc(2);
    drain("stall");
    check("accept_valid_drop", 32'(o_rx_valid), 32'h0);

    // Reset in the middle of data bit 3, then a clean frame.
    send_frame(8, 8, 16'h0099, 2'b00, 1'b0, 1'b0, 0, 1'b0, 3);
    check("post_rst_valid", 32'(o_rx_valid), 32'h0);
    send_frame(8, 8, 16'h003C, 2'b00, 1'b0, 1'b0, 0, 1'b1, -1);
    drain("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
